// File: rtl/hazard_stall_ctrl.sv
// rtl/hazard_stall_ctrl.sv - RAW hazard scoreboard, IF/ID freeze, branch flush and memory-wait freeze
// Optional FORWARDING_EN: only load-use against the EXE slot stalls (ALU results are forwarded).
module hazard_stall_ctrl #(
   parameter int REG_AW      = 4,
   parameter int STALL_CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [REG_AW-1:0]      src1,
   input  logic [REG_AW-1:0]      src2,
   input  logic                   Two_src,
   input  logic                   id_WB_EN,
   input  logic                   id_MEM_R_EN,
   input  logic [REG_AW-1:0]      Dest,
   input  logic                   branch_taken,
   input  logic                   mem_ready,
   output logic                   hazard,
   output logic                   freeze_if,
   output logic                   flush,
   output logic                   freeze_all,
   output logic [STALL_CNT_W-1:0] stall_count
);

   typedef struct packed {
      logic              v;
      logic              ld;
      logic [REG_AW-1:0] d;
   } slot_t;

   localparam int SLOT_EXE = 0;
   localparam int SLOT_MEM = 1;
   localparam int SLOT_WB  = 2;

   localparam logic [STALL_CNT_W-1:0] CNT_ONE = {{(STALL_CNT_W-1){1'b0}}, 1'b1};

   // Index 0 = EXE, 1 = MEM, 2 = WB; WB is tracked but never compared,
   // because the register file writes before ID reads in the same cycle.
   slot_t sb [3];

   logic m1;
   logic m2;
   logic rh;
   logic stall_inc;

   always_comb begin
      m1 = 1'b0;
      m2 = 1'b0;
`ifdef FORWARDING_EN
      m1 = sb[SLOT_EXE].v & sb[SLOT_EXE].ld & (sb[SLOT_EXE].d == src1);
      m2 = Two_src & sb[SLOT_EXE].v & sb[SLOT_EXE].ld & (sb[SLOT_EXE].d == src2);
`else
      m1 = (sb[SLOT_EXE].v & (sb[SLOT_EXE].d == src1))
         | (sb[SLOT_MEM].v & (sb[SLOT_MEM].d == src1));
      m2 = Two_src & ((sb[SLOT_EXE].v & (sb[SLOT_EXE].d == src2))
                    | (sb[SLOT_MEM].v & (sb[SLOT_MEM].d == src2)));
`endif
      rh = m1 | m2;
   end

   // A taken branch wins over a hazard so the PC can load the target.
   assign flush      = branch_taken;
   assign hazard     = rh | branch_taken;
   assign freeze_if  = (rh & ~branch_taken) | ~mem_ready;
   assign freeze_all = ~mem_ready;
   assign stall_inc  = rh & ~branch_taken & mem_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 3; i++) begin
            sb[i] <= '0;
         end
         stall_count <= '0;
      end else if (mem_ready) begin
         sb[SLOT_EXE] <= '{v: id_WB_EN & ~hazard, ld: id_MEM_R_EN & ~hazard, d: Dest};
         sb[SLOT_MEM] <= sb[SLOT_EXE];
         sb[SLOT_WB]  <= sb[SLOT_MEM];
         if (stall_inc && (stall_count != {STALL_CNT_W{1'b1}})) begin
            stall_count <= stall_count + CNT_ONE;
         end
      end
   end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Pipeline hazard/stall controller for the 5-stage core; sits beside ID_Stage.
- Keeps a 3-slot in-flight destination scoreboard (EXE, MEM, WB) and detects RAW hazards against the ID sources.
- Drives the ID `hazard` input, IF/ID freeze, wrong-path flush on taken branch, and a global freeze while memory is not ready.

Parameters:
- REG_AW, 4, register address width
- STALL_CNT_W, 16, width of saturating stall-cycle counter

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- src1  in  REG_AW  ID first source (Rn)
- src2  in  REG_AW  ID second source (Rm, or Rd for stores)
- Two_src  in  1  src2 is a real operand
- id_WB_EN  in  1  raw control-unit WB_EN of the ID instruction
- id_MEM_R_EN  in  1  raw control-unit MEM_R_EN of the ID instruction
- Dest  in  REG_AW  ID destination (Rd)
- branch_taken  in  1  taken branch resolved in EXE this cycle
- mem_ready  in  1  data memory can complete this cycle
- hazard  out  1  to ID_Stage; zeroes issued control signals
- freeze_if  out  1  hold PC and IF/ID register
- flush  out  1  clear IF/ID register
- freeze_all  out  1  hold every pipeline register
- stall_count  out  STALL_CNT_W  cycles lost to RAW stalls

Behaviour:
- Slot contents: `v` (writes a register), `d` (dest), `ld` (load). Slots are `sb_exe`, `sb_mem`, `sb_wb`.
- Reset (sync, `rst=1` at posedge): all slot `v`/`ld` and `stall_count` = 0.
- Outputs are combinational from slots and inputs, so they are 0 after reset when `branch_taken=0` and `mem_ready=1`.
- Raw hazard `rh`:
  - `m1 = sb_exe.v & sb_exe.d==src1`, or the same test against `sb_mem`.
  - `m2` is the same test on `src2`, gated by `Two_src`.
  - `rh = m1 | m2`.
  - The WB slot is not checked: the register file writes before ID reads in the same cycle.
- `flush = branch_taken`.
- `hazard = rh | branch_taken`, so a wrong-path ID instruction is issued as a bubble.
- `freeze_if = (rh & ~branch_taken) | ~mem_ready`. On a taken branch the PC must load the target even if a hazard is present.
- `freeze_all = ~mem_ready`.
- Slot update at posedge when `mem_ready=1`:
  - `sb_exe <= {v: id_WB_EN & ~hazard, d: Dest, ld: id_MEM_R_EN & ~hazard}`
  - `sb_mem <= sb_exe`, `sb_wb <= sb_mem`.
- When `mem_ready=0`: all slots hold, counter holds, and `hazard` is still driven. ID is frozen, so no double issue.
- `branch_taken` does not touch `sb_mem`/`sb_wb`. The branch instruction is in EXE and older instructions complete normally.
- `stall_count` increments by 1 on each posedge with `rh & ~branch_taken & mem_ready`. It saturates at all-ones and never wraps.
- `rst` asserted mid-stall or mid-freeze clears everything on that edge; the next cycle has no hazard.
- Latency: a producer in ID stalls a dependent consumer for 2 cycles (no forwarding); `hazard` takes effect in the same cycle.

Optional Feature:
- Macro: FORWARDING_EN.
- Defined:
  - `rh` considers only `sb_exe` entries with `ld=1` (load-use).
  - ALU results are forwarded by the EXE forwarding mux, so a load-use dependency stalls exactly 1 cycle.
  - Non-load dependencies never stall.
- Undefined: behaviour as above, 2-cycle stall for any EXE/MEM match.

Test Plan:
- ADD R1 (`id_WB_EN=1`, `Dest=1`), then consumer `src1=1` -> `hazard=1`, `freeze_if=1` for 2 cycles then 0; `stall_count=2`. With FORWARDING_EN: 0 stalls.
- LDR R3 then consumer `src2=3`, `Two_src=1` -> with FORWARDING_EN: 1-cycle stall, `stall_count=1`. Repeat with `Two_src=0` -> no stall.
- `branch_taken=1` while `rh=1` -> `flush=1`, `hazard=1`, `freeze_if=0`; next `sb_exe.v=0`; `stall_count` unchanged.
- `mem_ready=0` for 3 cycles with a MEM-slot producer -> `freeze_all=1`, slots unchanged; after `mem_ready=1` the stall count resumes from the held value.
- Preload `stall_count=16'hFFFE` via repeated stalls (shorter counter in bench) -> saturates at all-ones and holds.
- `rst=1` during an active stall -> next cycle `hazard=0`, `stall_count=0`, all slots invalid.
